// File: rtl/hamming_pkg.sv
// Hamming(15,11) shared definitions: widths, parity positions and the
// reference encoder. Shared between the encoder stream and the corrector stage.
// Codeword index i holds Hamming position i+1.
package hamming_pkg;

  localparam int unsigned DATA_W = 11;
  localparam int unsigned CODE_W = 15;
  localparam int unsigned PAR_W  = 4;

  // Parity bit indices (Hamming positions 1, 2, 4, 8)
  localparam int unsigned P0_IDX = 0;
  localparam int unsigned P1_IDX = 1;
  localparam int unsigned P2_IDX = 3;
  localparam int unsigned P3_IDX = 7;

  // Build the codeword: place data bits, then fill the four parity bits
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] cw;
    cw         = '0;
    cw[2]      = data[0];
    cw[6:4]    = data[3:1];
    cw[14:8]   = data[10:4];
    cw[P0_IDX] = cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10] ^ cw[12] ^ cw[14];
    cw[P1_IDX] = cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10] ^ cw[13] ^ cw[14];
    cw[P2_IDX] = cw[4] ^ cw[5] ^ cw[6] ^ cw[11] ^ cw[12] ^ cw[13] ^ cw[14];
    cw[P3_IDX] = ^cw[14:8];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_fifo.sv
// Synchronous FIFO for codewords, synchronous active-low reset.
// Ports: clk, rst_n, push/wr_data (write tail), pop/rd_data (read head,
// rd_data is the raw head entry), full, empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module hamming_fifo
  import hamming_pkg::*;
#(
  parameter int unsigned WIDTH = CODE_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      case ({do_push, do_pop})
        2'b10:   count <= CNT_W'(count + CNT_W'(1));
        2'b01:   count <= CNT_W'(count - CNT_W'(1));
        default: count <= count;
      endcase
    end
  end

  // Storage; contents are don't-care while empty, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/codifica_hamming_stream.sv
// Streaming Hamming(15,11) encoder with codeword buffer.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data upstream
// handshake; inj_en/inj_pos error injection; out_valid/out_ready/out_codeword
// downstream handshake; word_count = codewords popped since reset (wraps).
// Build option: define HAMMING_ERR_INJECT_EN to enable single-bit error
// injection at push time; otherwise inj_en/inj_pos are ignored.
module codifica_hamming_stream
  import hamming_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              inj_en,
  input  logic [3:0]        inj_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_codeword,
  output logic [CNT_W-1:0]  word_count
);

  logic [CODE_W-1:0] clean_cw;
  logic [CODE_W-1:0] stored_cw;
  logic [CODE_W-1:0] head_cw;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign clean_cw = encode(in_data);

`ifdef HAMMING_ERR_INJECT_EN
  // Flip position inj_pos (1-based); position 0 leaves the word clean
  logic [CODE_W-1:0] flip_mask;
  always_comb begin
    flip_mask = '0;
    if (inj_en && (inj_pos != 4'd0)) begin
      flip_mask = CODE_W'(CODE_W'(1) << (inj_pos - 4'd1));
    end
  end
  assign stored_cw = clean_cw ^ flip_mask;
`else
  logic unused_inj;
  assign unused_inj = ^{inj_en, inj_pos};
  assign stored_cw  = clean_cw;
`endif

  // Ready depends only on registered occupancy, never on out_ready
  assign in_ready     = !fifo_full;
  assign out_valid    = !fifo_empty;
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign out_codeword = fifo_empty ? '0 : head_cw;

  hamming_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (stored_cw),
    .pop     (pop),
    .rd_data (head_cw),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Delivered-word counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_count <= '0;
    end else if (pop) begin
      word_count <= CNT_W'(word_count + CNT_W'(1));
    end
  end

endmodule

// File: tb/tb_codifica_hamming_stream.sv
module tb_codifica_hamming_stream;
  import hamming_pkg::*;

  localparam int unsigned TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                inj_en;
  logic [3:0]          inj_pos;
  logic                out_valid;
  logic                out_ready;
  logic [CODE_W-1:0]   out_codeword;
  logic [TB_CNT_W-1:0] word_count;

  int checks   = 0;
  int failures = 0;

  codifica_hamming_stream #(
    .FIFO_DEPTH (2),
    .CNT_W      (TB_CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .inj_en       (inj_en),
    .inj_pos      (inj_pos),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_codeword (out_codeword),
    .word_count   (word_count)
  );

  always #5 clk = ~clk;

  // Independent reference: positional Hamming definition
  function automatic logic [CODE_W-1:0] ref_enc(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    int k;
    logic p;
    c = '0;
    k = 0;
    for (int pos = 1; pos <= 15; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 15; pos++) begin
        if (((pos >> b) & 1) == 1 && pos != (1 << b)) p = p ^ c[pos-1];
      end
      c[(1 << b) - 1] = p;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] vec_in  [4];
  logic [CODE_W-1:0] vec_out [4];
  logic [DATA_W-1:0] wa, wb, wc;
  logic [CODE_W-1:0] inj_exp;

  initial begin
    vec_in[0] = 11'h000; vec_out[0] = 15'h0000;
    vec_in[1] = 11'h7FF; vec_out[1] = 15'h7FFF;
    vec_in[2] = 11'h001; vec_out[2] = 15'h0007;
    vec_in[3] = 11'h400; vec_out[3] = 15'h408B;
    wa = 11'h123; wb = 11'h456; wc = 11'h789;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    inj_en = 1'b0; inj_pos = 4'd0; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_codeword", 32'(out_codeword), 32'd0);
    chk("reset_count", 32'(word_count), 32'd0);

    // Encoding vectors, one cycle push-to-valid latency
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vec_in[i];
      #1;
      chk("no_comb_path", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("enc_valid", 32'(out_valid), 32'd1);
      chk("enc_codeword", 32'(out_codeword), 32'(vec_out[i]));
      tick();
      chk("enc_drained", 32'(out_valid), 32'd0);
    end
    chk("enc_count", 32'(word_count), 32'd4);

    // Backpressure: third word refused while full
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = wa;
    tick();
    chk("bp_ready_1", 32'(in_ready), 32'd1);
    in_data = wb;
    tick();
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    in_data = wc;
    tick();
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_head_a", 32'(out_codeword), 32'(ref_enc(wa)));
    out_ready = 1'b1;
    tick();
    chk("bp_head_b", 32'(out_codeword), 32'(ref_enc(wb)));
    chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_head_c", 32'(out_codeword), 32'(ref_enc(wc)));
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_count", 32'(word_count), 32'd7);

    // Simultaneous push/pop at occupancy 1
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 11'(5);
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = 11'(i * 37 + 5);
      chk("pp_valid", 32'(out_valid), 32'd1);
      chk("pp_ready", 32'(in_ready), 32'd1);
      chk("pp_order", 32'(out_codeword), 32'(ref_enc(11'((i - 1) * 37 + 5))));
      tick();
    end
    in_valid = 1'b0;
    chk("pp_last", 32'(out_codeword), 32'(ref_enc(11'(10 * 37 + 5))));
    tick();
    chk("pp_drained", 32'(out_valid), 32'd0);
    chk("pp_count_wrap", 32'(word_count), 32'd2);

    // Reset with two words buffered; inputs ignored during reset
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = wa;
    tick();
    in_data = wb;
    tick();
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_codeword", 32'(out_codeword), 32'd0);
    tick();
    chk("rst_no_stale", 32'(out_valid), 32'd0);
    chk("rst_count_hold", 32'(word_count), 32'd0);

    // Counter wrap: 17 pops on a 4-bit counter
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 11'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_count", 32'(word_count), 32'd1);
    chk("wrap_drained", 32'(out_valid), 32'd0);

    // Error injection
`ifdef HAMMING_ERR_INJECT_EN
    inj_exp = 15'h0017;
`else
    inj_exp = 15'h0007;
`endif
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 11'h001; inj_en = 1'b1; inj_pos = 4'd5;
    tick();
    inj_pos = 4'd0;
    tick();
    in_valid = 1'b0; inj_en = 1'b0;
    chk("inj_pos5", 32'(out_codeword), 32'(inj_exp));
    out_ready = 1'b1;
    tick();
    chk("inj_pos0", 32'(out_codeword), 32'h0007);
    tick();
    chk("inj_drained", 32'(out_valid), 32'd0);
    chk("final_count", 32'(word_count), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
